// File: rtl/truth_table_scanner.sv
// rtl/truth_table_scanner.sv - sweeps every input combination of a gate under test and captures its truth table
module truth_table_scanner #(
    parameter int                      N_IN     = 2,
    parameter int                      SETTLE   = 1,
    parameter logic [(2**N_IN)-1:0]    EXPECTED = 4'b0001
) (
    input  logic                       i_clock,
    input  logic                       i_reset_,
    input  logic                       i_start,
    output logic [N_IN-1:0]            o_x,
    input  logic                       i_z,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [(2**N_IN)-1:0]       o_table,
    output logic                       o_match
);

    localparam int                W        = 2**N_IN;
    localparam logic [N_IN:0]     LAST_IDX = (N_IN+1)'(W-1);
    localparam logic [N_IN:0]     IDX_ONE  = (N_IN+1)'(1);
    localparam logic [3:0]        CNT_INIT = 4'(SETTLE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [N_IN:0]     r_idx;
    logic [3:0]        r_cnt;
    logic [N_IN-1:0]   r_x;
    logic              r_busy;
    logic              r_done;
    logic [W-1:0]      r_table;
    logic              r_match;

    logic [W-1:0]      w_table_smp;
    logic [N_IN:0]     w_idx_inc;

    // Table as it will look once the current z sample is written in; bits above idx are still 0
    always_comb begin
        w_table_smp                      = r_table;
        w_table_smp[r_idx[N_IN-1:0]]     = i_z;
        w_idx_inc                        = r_idx + IDX_ONE;
    end

    // Scan sequencer: accept start, hold each combination SETTLE+1 cycles, sample z on the last edge
    always_ff @(posedge i_clock or negedge i_reset_) begin
        if (!i_reset_) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_x     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_table <= '0;
            r_match <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_x    <= '0;
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_idx   <= '0;
                        r_cnt   <= CNT_INIT;
                        r_table <= '0;
                        r_match <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_table <= w_table_smp;
                        if (r_idx == LAST_IDX) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_match <= (w_table_smp == EXPECTED);
                            r_state <= S_DONE;
                        end else begin
                            r_idx <= w_idx_inc;
                            r_x   <= w_idx_inc[N_IN-1:0];
                            r_cnt <= CNT_INIT;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_x     <= '0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_x     = r_x;
    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_table = r_table;
    assign o_match = r_match;

endmodule

// File: tb/tb_truth_table_scanner.sv
// tb/tb_truth_table_scanner.sv - directed vector bench for truth_table_scanner
module tb_truth_table_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       gate_or;
    logic       start_a, start_b, start_c;
    logic [1:0] x_a, x_b;
    logic [2:0] x_c;
    logic       z_a, z_b, z_c;
    logic       busy_a, busy_b, busy_c;
    logic       done_a, done_b, done_c;
    logic [3:0] tbl_a, tbl_b;
    logic [7:0] tbl_c;
    logic       match_a, match_b, match_c;

    // gates under test
    assign z_a = gate_or ? (|x_a) : ~(|x_a);
    assign z_b = ~(|x_b);
    assign z_c = ~(|x_c);

    truth_table_scanner #(.N_IN(2), .SETTLE(1), .EXPECTED(4'b0001)) dut_a (
        .i_clock(clk), .i_reset_(rst_n), .i_start(start_a), .o_x(x_a), .i_z(z_a),
        .o_busy(busy_a), .o_done(done_a), .o_table(tbl_a), .o_match(match_a));

    truth_table_scanner #(.N_IN(2), .SETTLE(0), .EXPECTED(4'b0001)) dut_b (
        .i_clock(clk), .i_reset_(rst_n), .i_start(start_b), .o_x(x_b), .i_z(z_b),
        .o_busy(busy_b), .o_done(done_b), .o_table(tbl_b), .o_match(match_b));

    truth_table_scanner #(.N_IN(3), .SETTLE(2), .EXPECTED(8'b00000001)) dut_c (
        .i_clock(clk), .i_reset_(rst_n), .i_start(start_c), .o_x(x_c), .i_z(z_c),
        .o_busy(busy_c), .o_done(done_c), .o_table(tbl_c), .o_match(match_c));

    typedef struct {
        logic       start;
        logic       gate_or;
        logic [1:0] x;
        logic       busy;
        logic       done;
        logic [3:0] tbl;
        logic       match;
    } vec_t;

    vec_t vecs [21];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic s, input logic g, input logic [1:0] x,
                                input logic b, input logic d, input logic [3:0] t,
                                input logic m);
        vec_t v;
        v.start = s; v.gate_or = g; v.x = x; v.busy = b; v.done = d; v.tbl = t; v.match = m;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input int which, output logic d, output logic b,
                          output logic [7:0] xv, output logic [7:0] tv, output logic m);
        case (which)
            0:       begin d = done_a; b = busy_a; xv = 8'(x_a); tv = 8'(tbl_a); m = match_a; end
            1:       begin d = done_b; b = busy_b; xv = 8'(x_b); tv = 8'(tbl_b); m = match_b; end
            default: begin d = done_c; b = busy_c; xv = 8'(x_c); tv = 8'(tbl_c); m = match_c; end
        endcase
    endtask

    // One full scan on the selected instance: counts edges from the start edge to done
    task automatic run_scan(input int which, input int settle, input int n_in,
                            input int exp_edges, input logic [7:0] exp_tbl, input logic exp_m);
        int         edges;
        logic       d, b, m;
        logic [7:0] xv, tv;
        case (which)
            0:       start_a = 1'b1;
            1:       start_b = 1'b1;
            default: start_c = 1'b1;
        endcase
        tick();
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        sample(which, d, b, xv, tv, m);
        chk("accept_busy", 8'(b), 8'd1);
        chk("accept_table", tv, 8'd0);
        chk("accept_x", xv, 8'd0);
        edges = 0;
        while (!d && edges < 200) begin
            tick();
            edges++;
            sample(which, d, b, xv, tv, m);
            if (!d) chk("scan_x", xv, 8'(edges / (settle + 1)));
        end
        chk("done_edges", 8'(edges), 8'(exp_edges));
        chk("done_busy", 8'(b), 8'd0);
        chk("done_table", tv, exp_tbl);
        chk("done_match", 8'(m), 8'(exp_m));
        chk("done_x", xv, 8'((1 << n_in) - 1));
        tick();
        sample(which, d, b, xv, tv, m);
        chk("post_done", 8'(d), 8'd0);
        chk("post_x", xv, 8'd0);
        chk("post_table", tv, exp_tbl);
        chk("post_match", 8'(m), 8'(exp_m));
    endtask

    initial begin
        // NOR scan with restarts during busy (edge 3) and DONE (edge 8), then OR scan from edge 10
        vecs[0]  = mk(1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 4'h0, 1'b0);
        vecs[1]  = mk(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 4'h0, 1'b0);
        vecs[2]  = mk(1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 4'h1, 1'b0);
        vecs[3]  = mk(1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 4'h1, 1'b0);
        vecs[4]  = mk(1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 4'h1, 1'b0);
        vecs[5]  = mk(1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 4'h1, 1'b0);
        vecs[6]  = mk(1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 4'h1, 1'b0);
        vecs[7]  = mk(1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 4'h1, 1'b0);
        vecs[8]  = mk(1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 4'h1, 1'b1);
        vecs[9]  = mk(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'h1, 1'b1);
        vecs[10] = mk(1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 4'h0, 1'b0);
        vecs[11] = mk(1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 4'h0, 1'b0);
        vecs[12] = mk(1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 4'h0, 1'b0);
        vecs[13] = mk(1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 4'h0, 1'b0);
        vecs[14] = mk(1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 4'h2, 1'b0);
        vecs[15] = mk(1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 4'h2, 1'b0);
        vecs[16] = mk(1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 4'h6, 1'b0);
        vecs[17] = mk(1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 4'h6, 1'b0);
        vecs[18] = mk(1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 4'he, 1'b0);
        vecs[19] = mk(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 4'he, 1'b0);
        vecs[20] = mk(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 4'he, 1'b0);

        rst_n = 1'b0; gate_or = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        #12;
        chk("rst_x", 8'(x_a), 8'd0);
        chk("rst_busy", 8'(busy_a), 8'd0);
        chk("rst_done", 8'(done_a), 8'd0);
        chk("rst_table", 8'(tbl_a), 8'd0);
        chk("rst_match", 8'(match_a), 8'd0);
        chk("rst_table_c", tbl_c, 8'd0);
        #11 rst_n = 1'b1;
        tick();
        tick();
        chk("idle_busy", 8'(busy_a), 8'd0);

        for (int k = 0; k < 21; k++) begin
            start_a = vecs[k].start;
            gate_or = vecs[k].gate_or;
            tick();
            chk($sformatf("v%0d_x", k), 8'(x_a), 8'(vecs[k].x));
            chk($sformatf("v%0d_busy", k), 8'(busy_a), 8'(vecs[k].busy));
            chk($sformatf("v%0d_done", k), 8'(done_a), 8'(vecs[k].done));
            chk($sformatf("v%0d_table", k), 8'(tbl_a), 8'(vecs[k].tbl));
            chk($sformatf("v%0d_match", k), 8'(match_a), 8'(vecs[k].match));
        end
        start_a = 1'b0;
        gate_or = 1'b0;
        tick();

        // asynchronous reset while idx=2
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (4) tick();
        chk("pre_rst_x", 8'(x_a), 8'd2);
        chk("pre_rst_table", 8'(tbl_a), 8'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_x", 8'(x_a), 8'd0);
        chk("arst_busy", 8'(busy_a), 8'd0);
        chk("arst_done", 8'(done_a), 8'd0);
        chk("arst_table", 8'(tbl_a), 8'd0);
        chk("arst_match", 8'(match_a), 8'd0);
        #2 rst_n = 1'b1;
        tick();
        tick();
        chk("after_rst_busy", 8'(busy_a), 8'd0);
        chk("after_rst_x", 8'(x_a), 8'd0);
        run_scan(0, 1, 2, 8, 8'h01, 1'b1);

        // SETTLE=0 NOR
        run_scan(1, 0, 2, 4, 8'h01, 1'b1);
        // 3-input NOR, SETTLE=2
        run_scan(2, 2, 3, 24, 8'h01, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
